// File: rtl/fetch_buf_pkg.sv
// Shared types and constants for the decoupled instruction fetch stage.
package fetch_buf_pkg;

  localparam int FB_ADDR_W          = 32;
  localparam int FB_INST_W          = 32;
  localparam int FB_IBUF_DEPTH      = 4;
  localparam int FB_MAX_OUTSTANDING = 2;

  // addi x0, x0, 0
  localparam logic [FB_INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] pc;
    logic [FB_INST_W-1:0] inst;
    logic                 err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf_sync_fifo.sv
// Small synchronous FIFO with a flush input; head is read straight from storage.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_buf.sv
// Fetch stage: decoupled req/rsp memory port, in-order pc queue and instruction buffer.
module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int ADDR_W          = FB_ADDR_W,
  parameter int INST_W          = FB_INST_W,
  parameter int IBUF_DEPTH      = FB_IBUF_DEPTH,
  parameter int MAX_OUTSTANDING = FB_MAX_OUTSTANDING
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              if_ready,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  input  logic              id_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  output logic              if_valid
);

  localparam int PCQ_CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IB_CW  = $clog2(IBUF_DEPTH) + 1;
  localparam int SW     = IB_CW + 1;

  logic [PCQ_CW-1:0] pcq_cnt, drop_cnt;
  logic [IB_CW-1:0]  ibuf_cnt;
  logic [SW-1:0]     out_sum, occ_sum;
  logic              credit, req_fire, rsp_take, ibuf_pop;
  logic              pcq_full, pcq_empty, ibuf_full, ibuf_empty;
  logic [ADDR_W-1:0] pcq_head;
  fetch_entry_t      ibuf_din, ibuf_head;

  // Requests in flight include those whose responses will be dropped; the
  // second term reserves an ibuf slot for every request already issued.
  assign out_sum = SW'(pcq_cnt) + SW'(drop_cnt);
  assign occ_sum = SW'(pcq_cnt) + SW'(ibuf_cnt);
  assign credit  = (out_sum < SW'(MAX_OUTSTANDING)) && (occ_sum < SW'(IBUF_DEPTH));

  assign if_ready      = credit && mem_req_ready && !flush && !rst;
  assign mem_req_valid = pc_valid && credit && !flush && !rst;
  assign mem_req_addr  = pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_take = mem_rsp_valid && !flush && !rst && (drop_cnt == '0);
  assign ibuf_pop = if_valid && id_ready && !flush;

  always_comb begin
    ibuf_din      = '0;
    ibuf_din.pc   = FB_ADDR_W'(pcq_head);
    ibuf_din.inst = FB_INST_W'(mem_rsp_data);
    ibuf_din.err  = mem_rsp_err;
  end

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (req_fire),
    .din   (pc),
    .pop   (rsp_take),
    .head  (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_cnt)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (rsp_take),
    .din   (ibuf_din),
    .pop   (ibuf_pop),
    .head  (ibuf_head),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_cnt)
  );

  // On redirect every request still in the pc queue becomes a response to drop.
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (flush)
      drop_cnt <= drop_cnt + pcq_cnt - PCQ_CW'(mem_rsp_valid);
    else if (mem_rsp_valid && drop_cnt != '0)
      drop_cnt <= drop_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mem_rsp_valid) assert (!pcq_empty || drop_cnt != '0);
      assert (out_sum <= SW'(MAX_OUTSTANDING));
      assert (!(req_fire && pcq_full));
      assert (!(rsp_take && ibuf_full && !ibuf_pop));
    end
  end

  assign if_valid = !ibuf_empty;
  assign inst     = if_valid ? INST_W'(ibuf_head.inst) : INST_W'(INST_NOP);
  assign inst_pc  = if_valid ? ADDR_W'(ibuf_head.pc) : '0;
  assign inst_err = if_valid && ibuf_head.err;

endmodule

// File: tb/tb_fetch_buf.sv
// Directed and random fetch traffic; a monitor checks id-side entries against a scoreboard.
module tb_fetch_buf;
  import fetch_buf_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0, flush = 1'b0, mem_req_ready = 1'b0, id_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        if_ready, mem_req_valid, inst_err, if_valid;
  logic [31:0] mem_req_addr, inst, inst_pc;

  always #5 clk = ~clk;

  fetch_buf dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .if_ready(if_ready), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .id_ready(id_ready), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .if_valid(if_valid)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  exp_t  exp_q[$];
  pend_t pend_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int m_pcq = 0, m_drop = 0, m_ibuf = 0, mem_k = 1, last_due = 0;
  int dut_fires = 0, dut_pops = 0, first_pop = -1, last_pop = -1;
  logic        nx_rst = 1'b1, nx_pc_valid = 1'b0, nx_flush = 1'b0;
  logic        nx_id_ready = 1'b0, nx_req_ready = 1'b1;
  logic [31:0] nx_pc = '0;

  // addi x1, x0, n with n taken from the word address
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return 32'h0010_0093 + {a[13:2], 20'h0};
  endfunction
  function automatic logic mderr(input logic [31:0] a);
    return a[4:2] == 3'b010;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: apply queued inputs, play memory, check control outputs, advance the model.
  task automatic step();
    logic rv, cr, fire, take, pop, exp_mrv;
    logic [31:0] ra;
    @(negedge clk);
    rst = nx_rst; pc = nx_pc; pc_valid = nx_pc_valid; flush = nx_flush;
    id_ready = nx_id_ready; mem_req_ready = nx_req_ready;
    rv = 1'b0; ra = '0;
    if (!nx_rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rv = 1'b1; ra = pend_q[0].addr; void'(pend_q.pop_front());
    end
    mem_rsp_valid = rv;
    mem_rsp_data  = rv ? mdata(ra) : 32'hdead_beef;
    mem_rsp_err   = rv && mderr(ra);
    #1;
    cr      = (m_pcq + m_drop < 2) && (m_pcq + m_ibuf < 4);
    exp_mrv = !rst && cr && pc_valid && !flush;
    chk("if_ready", if_ready, !rst && cr && mem_req_ready && !flush);
    chk("mem_req_valid", mem_req_valid, exp_mrv);
    if (exp_mrv) chk("mem_req_addr", mem_req_addr, pc);
    chk("if_valid", if_valid, m_ibuf > 0);
    if (mem_req_valid && mem_req_ready) dut_fires++;
    if (!rst && if_valid && id_ready && !flush) begin
      dut_pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    fire = exp_mrv && mem_req_ready;
    take = rv && !flush && m_drop == 0;
    pop  = m_ibuf > 0 && id_ready && !flush;
    if (rst) begin
      m_pcq = 0; m_drop = 0; m_ibuf = 0; last_due = 0;
      pend_q.delete(); exp_q.delete();
    end else begin
      if (flush) begin
        m_drop = m_drop + m_pcq - (rv ? 1 : 0);
        m_pcq = 0; m_ibuf = 0;
        exp_q.delete();
      end else begin
        if (rv && m_drop > 0) m_drop--;
        if (take) begin m_pcq--; m_ibuf++; end
        if (pop) m_ibuf--;
      end
      if (fire) begin
        m_pcq++;
        exp_q.push_back('{pc: pc, inst: mdata(pc), err: mderr(pc)});
        last_due = (cyc + mem_k > last_due + 1) ? cyc + mem_k : last_due + 1;
        pend_q.push_back('{addr: pc, due: last_due});
        nx_pc = pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic fire_n(input int n, input string name);
    int d0, i;
    d0 = dut_fires;
    nx_pc_valid = 1'b1;
    for (i = 0; i < 40 && dut_fires - d0 < n; i++) step();
    nx_pc_valid = 1'b0;
    chk(name, dut_fires - d0, n);
  endtask

  task automatic drain(input int n);
    nx_pc_valid = 1'b0; nx_flush = 1'b0; nx_id_ready = 1'b1; nx_req_ready = 1'b1;
    repeat (n) step();
  endtask

  // Monitor: whenever id takes the head entry, compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (if_valid === 1'b1) begin
        if (id_ready && !flush && !rst) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_entry: got pc %0h expected none (cycle %0d)", inst_pc, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("inst", inst, e.inst);
            chk("inst_pc", inst_pc, e.pc);
            chk("inst_err", inst_err, e.err);
          end
        end
      end else begin
        chk("idle_inst", inst, 32'h0000_0013);
        chk("idle_pc", inst_pc, 32'h0);
        chk("idle_err", inst_err, 1'b0);
      end
    end
  end

  initial begin
    int d0, i;
    logic seen;
    step(); step();
    nx_rst = 1'b0;

    // single fetch, k=1
    nx_pc = 32'h8000_0000; nx_pc_valid = 1'b1; nx_id_ready = 1'b1; mem_k = 1;
    step();
    nx_pc_valid = 1'b0;
    step(); chk("single_rsp_cycle", if_valid, 1'b0);
    step(); chk("single_valid", if_valid, 1'b1);
    chk("single_inst", inst, 32'h0010_0093);
    chk("single_pc", inst_pc, 32'h8000_0000);
    step(); chk("single_nop", inst, 32'h0000_0013);

    // streaming 8 sequential pcs, includes the faulting 0x80000008
    nx_pc = 32'h8000_0000; first_pop = -1; d0 = dut_pops;
    fire_n(8, "stream_issued");
    drain(6);
    chk("stream_pops", dut_pops - d0, 8);
    chk("stream_no_bubble", last_pop - first_pop, 7);

    // backpressure: id stalled for 10 cycles
    nx_id_ready = 1'b0; nx_pc = 32'h8000_0040; nx_pc_valid = 1'b1; d0 = dut_fires;
    repeat (10) step();
    chk("bp_fires", dut_fires - d0, 4);
    chk("bp_if_ready", if_ready, 1'b0);
    chk("bp_req_valid", mem_req_valid, 1'b0);
    nx_id_ready = 1'b1;
    fire_n(4, "bp_resume");
    drain(8);

    // flush with two requests in flight, k=3
    mem_k = 3; nx_pc = 32'h8000_0100;
    fire_n(2, "flush_setup");
    nx_flush = 1'b1; step(); nx_flush = 1'b0;
    nx_pc = 32'h8000_1000; nx_pc_valid = 1'b1; d0 = dut_fires; seen = 1'b0;
    for (i = 0; i < 20 && !seen; i++) begin
      step();
      if (dut_fires > d0) nx_pc_valid = 1'b0;
      if (if_valid) begin
        seen = 1'b1;
        chk("redirect_pc", inst_pc, 32'h8000_1000);
        chk("redirect_inst", inst, 32'h4010_0093);
      end
    end
    chk("redirect_seen", seen, 1'b1);
    drain(6);

    // flush in the same cycle as a response, k=2
    mem_k = 2; nx_pc = 32'h8000_0200;
    fire_n(2, "coinc_setup");
    nx_flush = 1'b1; step(); nx_flush = 1'b0;
    repeat (4) begin step(); chk("coinc_quiet", if_valid, 1'b0); end
    nx_pc = 32'h8000_0300;
    fire_n(1, "coinc_refetch");
    drain(6);

    // reset in the middle of traffic
    mem_k = 3; nx_pc = 32'h8000_0400;
    fire_n(2, "rst_setup");
    nx_rst = 1'b1; step(); step(); nx_rst = 1'b0;
    step(); chk("rst_if_valid", if_valid, 1'b0);

    // random traffic
    for (int r = 0; r < 10000; r++) begin
      nx_req_ready = ($urandom_range(0, 9) < 7);
      nx_id_ready  = ($urandom_range(0, 9) < 6);
      nx_pc_valid  = ($urandom_range(0, 9) < 8);
      nx_flush     = ($urandom_range(0, 59) == 0);
      if (nx_flush) nx_pc = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
      mem_k = $urandom_range(1, 4);
      step();
    end
    drain(20);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_if_valid", if_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
